// File: rtl/ip_pkg.sv
// Shared IPv4 constants, encoder state type and the ones-complement adder
// used by the header checksum logic.
package ip_pkg;

  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_TTL         = 8'd64;
  localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;
  localparam logic [4:0]  IP_HDR_BYTES   = 5'd20;
  localparam logic [15:0] IP_MAX_PAYLOAD = 16'd65515;

  localparam logic [7:0]  PROTO_TCP      = 8'd6;
  localparam logic [7:0]  PROTO_UDP      = 8'd17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CSUM,
    S_HDR,
    S_PAYLOAD,
    S_DONE
  } ip_enc_state_t;

  // 16-bit add with end-around carry; cannot overflow a second time.
  function automatic logic [15:0] ones_comp(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ip_encode_if.sv
// Byte streams of the IPv4 encoder: payload in from the transport framer,
// packet bytes out to the MAC framer.
interface ip_encode_if;

  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       dout_last;

  modport master (
    input  pl_data, pl_valid, dout_ready,
    output pl_ready, dout, dout_valid, dout_last
  );

  modport slave (
    output pl_data, pl_valid, dout_ready,
    input  pl_ready, dout, dout_valid, dout_last
  );

endinterface

// File: rtl/ip_hdr_word.sv
// Selects one 16-bit IPv4 header word (0..9) from the latched packet fields.
module ip_hdr_word
  import ip_pkg::*;
(
  input  logic [3:0]  word_idx,
  input  logic [15:0] total_len,
  input  logic [15:0] ident,
  input  logic [15:0] checksum,
  input  logic [7:0]  protocol,
  input  logic [31:0] sa,
  input  logic [31:0] da,
  output logic [15:0] word
);

  always_comb begin
    word = 16'h0000;
    case (word_idx)
      4'd0:    word = {IP_VER_IHL, 8'h00};
      4'd1:    word = total_len;
      4'd2:    word = ident;
      4'd3:    word = IP_FLAGS_DF;
      4'd4:    word = {IP_TTL, protocol};
      4'd5:    word = checksum;
      4'd6:    word = sa[31:16];
      4'd7:    word = sa[15:0];
      4'd8:    word = da[31:16];
      4'd9:    word = da[15:0];
      default: word = 16'h0000;
    endcase
  end

endmodule

// File: rtl/ip_encode.sv
// IPv4 transmit encoder: checksums the header over 10 cycles, then streams
// the 20 header bytes followed by the pass-through payload.
module ip_encode
  import ip_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] sa,
  input  logic [31:0] da,
  input  logic [7:0]  protocol,
  input  logic [15:0] payload_len,
  ip_encode_if.master bus,
  output logic        busy,
  output logic        done,
  output logic        err
);

  ip_enc_state_t state_reg, state_next;
  logic [31:0] sa_reg, sa_next;
  logic [31:0] da_reg, da_next;
  logic [7:0]  proto_reg, proto_next;
  logic [15:0] len_reg, len_next;
  logic [15:0] ident_reg, ident_next;
  logic [15:0] acc_reg, acc_next;
  logic [15:0] csum_reg, csum_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [4:0]  idx_reg, idx_next;
  logic [15:0] rem_reg, rem_next;
  logic        err_reg, err_next;

  logic [3:0]  word_sel;
  logic [15:0] hdr_word;
  logic [15:0] acc_sum;
  logic [15:0] total_len;

  assign total_len = len_reg + 16'd20;
  // CSUM walks the words by cycle count; HDR picks the word holding the current byte.
  assign word_sel  = (state_reg == S_CSUM) ? cnt_reg : idx_reg[4:1];
  assign acc_sum   = ones_comp(acc_reg, hdr_word);

  ip_hdr_word u_hdr_word (
    .word_idx  (word_sel),
    .total_len (total_len),
    .ident     (ident_reg),
    .checksum  (csum_reg),
    .protocol  (proto_reg),
    .sa        (sa_reg),
    .da        (da_reg),
    .word      (hdr_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      sa_reg    <= '0;
      da_reg    <= '0;
      proto_reg <= '0;
      len_reg   <= '0;
      ident_reg <= '0;
      acc_reg   <= '0;
      csum_reg  <= '0;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      rem_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sa_reg    <= sa_next;
      da_reg    <= da_next;
      proto_reg <= proto_next;
      len_reg   <= len_next;
      ident_reg <= ident_next;
      acc_reg   <= acc_next;
      csum_reg  <= csum_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      rem_reg   <= rem_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sa_next        = sa_reg;
    da_next        = da_reg;
    proto_next     = proto_reg;
    len_next       = len_reg;
    ident_next     = ident_reg;
    acc_next       = acc_reg;
    csum_next      = csum_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    rem_next       = rem_reg;
    err_next       = 1'b0;
    bus.dout       = 8'h00;
    bus.dout_valid = 1'b0;
    bus.dout_last  = 1'b0;
    bus.pl_ready   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (payload_len > IP_MAX_PAYLOAD) begin
            err_next = 1'b1;
          end else begin
            sa_next    = sa;
            da_next    = da;
            proto_next = protocol;
            len_next   = payload_len;
            acc_next   = 16'h0000;
            csum_next  = 16'h0000;
            cnt_next   = 4'd0;
            state_next = S_CSUM;
          end
        end
      end

      S_CSUM: begin
        acc_next = acc_sum;
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == 4'd9) begin
          csum_next  = ~acc_sum;
          idx_next   = 5'd0;
          state_next = S_HDR;
        end
      end

      S_HDR: begin
        bus.dout       = idx_reg[0] ? hdr_word[7:0] : hdr_word[15:8];
        bus.dout_valid = 1'b1;
        bus.dout_last  = (idx_reg == IP_HDR_BYTES - 5'd1) && (len_reg == 16'd0);
        if (bus.dout_ready) begin
          idx_next = idx_reg + 5'd1;
          if (idx_reg == IP_HDR_BYTES - 5'd1) begin
            rem_next   = len_reg;
            state_next = (len_reg == 16'd0) ? S_DONE : S_PAYLOAD;
          end
        end
      end

      S_PAYLOAD: begin
        bus.dout       = bus.pl_data;
        bus.dout_valid = bus.pl_valid;
        bus.pl_ready   = bus.dout_ready;
        bus.dout_last  = (rem_reg == 16'd1);
        if (bus.pl_valid && bus.dout_ready) begin
          rem_next = rem_reg - 16'd1;
          if (rem_reg == 16'd1) begin
            state_next = S_DONE;
          end
        end
      end

      S_DONE: begin
        ident_next = ident_reg + 16'd1;
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state_reg != S_IDLE);
  assign done = (state_reg == S_DONE);
  assign err  = err_reg;

endmodule

// File: doc/ip_encode.md
# ip_encode

Builds an IPv4 header and streams it byte-serially ahead of an upstream payload, producing one complete IPv4 packet per `start`. Sits on the transmit path between the transport-layer framer and the Ethernet MAC framer. It is the transmit-side counterpart of the IPv4 header decoder. The header checksum is computed in-block before the first byte leaves.

## Interface
- No parameters.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `sa` in 32: source address; latched on accepted `start`.
- `da` in 32: destination address; latched on accepted `start`.
- `protocol` in 8: IPv4 protocol field; latched on accepted `start`.
- `payload_len` in 16: payload byte count; latched on accepted `start`.
- `pl_data` in 8: payload byte.
- `pl_valid` in 1: payload byte available.
- `pl_ready` out 1: payload byte consumed this cycle.
- `dout` out 8: packet byte.
- `dout_valid` out 1: `dout` holds a valid byte.
- `dout_ready` in 1: downstream accepts the byte.
- `dout_last` out 1: `dout` is the final byte of the packet.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last byte is accepted.
- `err` out 1: one-cycle pulse when `start` is rejected.

## Operation
- **Header fields**, MSB first:
  - 0x45; 0x00
  - total_len = payload_len + 20
  - identification = 16-bit `ident` register
  - 0x4000 (DF set, offset 0)
  - TTL 0x40; `protocol`
  - checksum
  - `sa`; `da`
- **States:** IDLE, CSUM, HDR, PAYLOAD, DONE.
- **IDLE:**
  - `start` with payload_len ≤ 65515: latch inputs, clear the accumulator, go to CSUM.
  - `start` with payload_len > 65515: pulse `err` the next cycle and stay in IDLE. Nothing is latched and `ident` is unchanged.
- **CSUM:** exactly 10 cycles. Each cycle adds one header 16-bit word (words 0..9, checksum word taken as 0) into a 16-bit ones-complement accumulator.
  - Addition uses end-around carry: s = a + b (17 bits); result = s[15:0] + s[16].
  - Use `ones_comp` from the shared utils header.
  - checksum = ~accumulator. Then go to HDR with the byte index at 0.
- **HDR:** `dout_valid` = 1 and `dout` = header byte[index].
  - Index advances only on `dout_valid && dout_ready`.
  - When byte 19 is accepted: go to PAYLOAD, or to DONE if payload_len == 0.
- **PAYLOAD:** pass-through.
  - `dout` = `pl_data`, `dout_valid` = `pl_valid`, `pl_ready` = `dout_ready`.
  - A 16-bit remaining counter decrements on each transfer. Go to DONE when the last byte is accepted.
- **`dout_last`:** high on header byte 19 when payload_len == 0; otherwise high on the final payload byte.
- **DONE:** 1 cycle. Assert `done`, increment `ident` (wraps 0xFFFF → 0x0000), return to IDLE.
- `start` outside IDLE is ignored with no `err`.
- `pl_ready` = 0 outside PAYLOAD.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from `start`.
  - Exception: in PAYLOAD, `dout`/`dout_valid`/`pl_ready` are combinational from `pl_*`/`dout_ready`.
- **Latency:** `start` sampled at cycle 0 → CSUM in cycles 1..10 → first header byte valid in cycle 11.
- With `dout_ready` held high, header bytes occupy cycles 11..30.
- **Backpressure:** while `dout_valid && !dout_ready`, `dout` and `dout_last` hold stable.
- **Reset values:**
  - `dout` = 0 and `dout_valid`, `dout_last`, `pl_ready`, `busy`, `done`, `err` = 0.
  - `ident` = 0, state = IDLE.
- **Reset mid-packet:** abort immediately and return to IDLE next cycle with no `done`. `ident` returns to 0.
- **`ident` wrap:** no flag is raised.

## Structure
- Shared package `ip_pkg`:
  - `IP_VER_IHL` = 8'h45, `IP_TTL` = 8'd64, `IP_FLAGS_DF` = 16'h4000, `IP_HDR_BYTES` = 20, `IP_MAX_PAYLOAD` = 16'd65515
  - `PROTO_TCP` = 8'd6, `PROTO_UDP` = 8'd17
  - `ip_enc_state_t` enum
- One sub-module is natural: `ip_hdr_word`, a combinational mux from (latched fields, word index 0..9) → 16-bit header word. CSUM uses it directly; HDR selects the high or low byte of word index>>1.
- The header is never stored as a 160-bit shift register.

## Test plan
- **Known vector:** sa=C0A80001, da=C0A800C7, protocol=0x11, payload_len=95, first packet after reset.
  - Required: dout = 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7, then 95 payload bytes.
  - `dout_last` on the final byte, `done` one cycle after it.
- **Zero payload, same fields:** total_len 0x0014.
  - 20 bytes out, `dout_last` on byte 19, `pl_ready` never high.
- **Random `dout_ready` and `pl_valid` stalls:** byte sequence identical to the stall-free run.
  - No byte is duplicated or dropped; `dout` is stable while stalled.
- **Back-to-back packets:** identification reads 0x0000 then 0x0001, and the checksum differs accordingly.
  - `start` asserted mid-packet has no effect.
- **payload_len = 65516:** `err` pulses one cycle later, `busy` stays 0.
  - A following valid `start` still uses ident 0x0000.
- **`rst` asserted during the 5th header byte:** all outputs 0 next cycle and no `done`.
  - A subsequent `start` produces a correct full header with ident 0x0000.
